// File: rtl/logic_gate_pipe.sv
// Selectable WIDTH-bit logic gate array behind a one-stage valid/ready result register,
// with a registered zero flag and a saturating count of accepted operand beats.
module logic_gate_pipe #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   y,
    output logic               zero,
    output logic [COUNT_W-1:0] count
);

    logic [WIDTH-1:0] result;
    logic             accept;
    logic             consume;

    always_comb begin
        result = '0;
        unique case (op)
            3'b000: result = a & b;
            3'b001: result = a | b;
            3'b010: result = ~(a & b);
            3'b011: result = ~(a | b);
            3'b100: result = a ^ b;
            3'b101: result = ~(a ^ b);
            3'b110: result = ~a;
            3'b111: result[0] = ~|a;
            default: result = '0;
        endcase
    end

    // Pass-through on drain: a new beat may land in the same edge the old one leaves.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            y         <= '0;
            zero      <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            y         <= result;
            zero      <= (result == '0);
        end else if (consume) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (accept && (count != '1)) begin
            count <= count + COUNT_W'(1);
        end
    end

endmodule

// File: doc/logic_gate_pipe.md
Name: logic_gate_pipe

Overview:
- Parametrised, registered successor to the single-bit 2-input gate cells.
- Applies one of eight bitwise or reduction logic operations to two WIDTH-bit operands.
- Result is delivered through a one-stage valid/ready pipeline register, with a zero flag and a saturating transaction counter.
- Sits between operand sources and downstream datapath or checking logic wherever a selectable, back-pressurable gate array is needed.

Parameters:
- WIDTH, 8, operand and result width in bits (≥1).
- COUNT_W, 16, width of the accepted-transaction counter (≥1).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept an operand beat.
- op  in  3  operation select; sampled with operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result register holds a valid result.
- out_ready  in  1  downstream accepts result.
- y  out  WIDTH  registered result.
- zero  out  1  registered; 1 when y == 0 (valid only with out_valid).
- count  out  COUNT_W  number of accepted input beats, saturating.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: out_valid=0, y=0, zero=0, count=0. Any in-flight result is discarded immediately on assertion; no output beat is produced. First acceptance is possible on the first rising edge after deassertion.
- Op encoding, all computed bitwise across WIDTH:
  - 000 AND: a&b
  - 001 OR: a|b
  - 010 NAND: ~(a&b)
  - 011 NOR: ~(a|b)
  - 100 XOR: a^b
  - 101 XNOR: ~(a^b)
  - 110 NOT: ~a (b ignored)
  - 111 RNOR: y[0] = ~|a, y[WIDTH-1:1] = 0 (b ignored)
- There are no illegal op codes.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational, single-register pipe with pass-through on drain).
  - Input accepted on an edge where in_valid && in_ready.
  - Output consumed on an edge where out_valid && out_ready.
- Latency: exactly 1 cycle from acceptance to out_valid=1 with the result. Throughput is 1 beat/cycle while out_ready=1.
- Register update on each edge:
  - Accept, with or without a simultaneous consume: y ← f(op,a,b), zero ← (f==0), out_valid ← 1.
  - Consume without accept: out_valid ← 0. y and zero hold their last values.
  - Neither: all hold.
- Stall stability: while out_valid=1 && out_ready=0, y and zero must not change and in_ready=0.
- in_valid may drop without acceptance; no requirement is placed on the source to hold operands stable.
- count increments by 1 on each accepted beat and saturates at 2^COUNT_W−1 (no wrap). It is unaffected by the output side.
- WIDTH=1 degenerates to a registered single-bit gate. RNOR then equals NOT.

Test Plan:
- Reset → all outputs 0. Assert rst_n=0 asynchronously (mid-cycle) while out_valid=1 → out_valid, y, count clear immediately, with no clock edge needed.
- WIDTH=8, out_ready=1, a=0x0F, b=0x33; ops 000..101 on consecutive cycles → y = 0x03, 0x3F, 0xFC, 0xC0, 0x3C, 0xC3, each one cycle after its input. count=6.
- op=110, a=0xA5 → y=0x5A. op=111, a=0x00 → y=0x01, zero=0. op=111, a=0x10 → y=0x00, zero=1.
- Backpressure with out_ready=0:
  - Beat 1 (a=0x0F, b=0x33, NOR) accepted. Beat 2 (XOR) held off with in_ready=0 and y stays 0xC0 for 5 cycles.
  - Raise out_ready → beat 1 consumed and beat 2 accepted on the same edge. Next cycle y=0x3C, count=2.
- Back-to-back streaming of 10 beats with out_ready=1 → 10 consecutive out_valid cycles, no bubbles, results in order.
- COUNT_W=4, stream 20 accepted beats → count reads 15 after the 15th beat and stays 15.
